iram_loadable: RTL

- Parametrised successor to the fixed instruction ROM: synchronous-read instruction memory whose program is written at run time through a valid/ready load stream instead of being fixed at elaboration.
- Sits between the PC (fetch address) and the MBRU (fetched word).
- A small FSM gates fetch and load and tracks load progress.
- Exposes word count, checksum and truncation error so the testbench or host can verify the loaded program.

---
 rtl/iram_loadable.sv | 89 ++++++++
 1 files changed

// File: rtl/iram_loadable.sv
// Run-time loadable instruction memory between the PC and the MBRU.
// A valid/ready stream fills the array; fetches are live only once loaded.
module iram_loadable #(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int DEPTH    = 256,
  parameter int NOP_CODE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          run,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic [AW:0]   load_count,
  output logic [DW-1:0] load_sum,
  output logic          load_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [DW-1:0] NOP = DW'(NOP_CODE);

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    RUN
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [DW-1:0] mem [DEPTH];

  logic accept;
  logic at_end;
  logic hit;

  assign load_ready = (state == LOAD);
  assign run        = (state == RUN);
  assign accept     = load_ready & load_valid & ~load_start;
  assign at_end     = (ptr == LAST_PTR);
  // load_count never exceeds DEPTH, so this also bounds addr to the array
  assign hit        = run & ({1'b0, addr} < load_count);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[ptr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ptr        <= '0;
      load_count <= '0;
      load_sum   <= '0;
      load_err   <= 1'b0;
      dout       <= NOP;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_en;
      if (rd_en) begin
        dout <= hit ? mem[addr[PW-1:0]] : NOP;
      end
      if (load_start) begin
        state      <= LOAD;
        ptr        <= '0;
        load_count <= '0;
        load_sum   <= '0;
        load_err   <= 1'b0;
      end else if (accept) begin
        ptr        <= ptr + PW'(1);
        load_count <= load_count + (AW+1)'(1);
        load_sum   <= load_sum + load_data;
        if (load_last | at_end) begin
          state    <= RUN;
          load_err <= ~load_last;
        end
      end
    end
  end

endmodule
